switch_ctrl: RTL and testbench

SWITCH_CTRL -- requirements
Module: switch_ctrl

---
 rtl/switch_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_switch_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_ctrl.sv
// switch_ctrl: selects one of six designs onto a shared pad ring.
// A one-hot request on i_sel is registered and settle-filtered. A new target
// then drains the pads (outputs disabled, all designs in reset), moves the
// mux, holds the new design in reset, and finally enables the pads.
//
// Ports
//   i_clk      clock, all state on rising edge
//   i_rst      asynchronous active-high reset
//   i_sel      one-hot design request (0 = no design)
//   o_mux      active design index 0..5, 7 = none
//   o_dsn_rst  per-design reset, active-high
//   o_oe       pad output enables, 0x00 or 0xFF
//   o_busy     switch sequence in progress
//   o_err      sticky multi-hot request flag
//
// state  | meaning
// -------+--------------------------------------------------------------
// OFF    | no design selected, pads disabled, all designs in reset
// DRAIN  | pads disabled for pOE_DLY cycles before the mux moves
// RESET  | mux moved, new design held in reset for pRST_CYC cycles
// RUN    | pads enabled, only the active design out of reset

module switch_ctrl #(
  parameter int unsigned pSETTLE  = 8,
  parameter int unsigned pOE_DLY  = 2,
  parameter int unsigned pRST_CYC = 4,
  parameter bit          pTEST    = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_sel,
  output logic [2:0] o_mux,
  output logic [5:0] o_dsn_rst,
  output logic [7:0] o_oe,
  output logic       o_busy,
  output logic       o_err
);

  localparam int unsigned SETTLE_EFF = pTEST ? 1 : pSETTLE;
  localparam logic [7:0]  SETTLE_TC  = 8'(SETTLE_EFF);
  localparam logic [3:0]  OE_LOAD    = 4'(pOE_DLY - 1);
  localparam logic [3:0]  RST_LOAD   = 4'(pRST_CYC - 1);
  localparam logic [2:0]  MUX_NONE   = 3'd7;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RESET = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  function automatic logic [2:0] sel_idx(input logic [5:0] v);
    logic [2:0] idx;
    case (v)
      6'b000001: idx = 3'd0;
      6'b000010: idx = 3'd1;
      6'b000100: idx = 3'd2;
      6'b001000: idx = 3'd3;
      6'b010000: idx = 3'd4;
      6'b100000: idx = 3'd5;
      default:   idx = MUX_NONE;
    endcase
    return idx;
  endfunction

  logic [5:0] r_req;
  logic       w_multi;
  logic [5:0] w_clean;
  logic [5:0] r_flt_val;
  logic [7:0] r_flt_cnt;
  logic [7:0] w_held;
  logic       w_acc;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_tgt;
  logic [5:0] w_tgt_nxt;
  logic [3:0] r_tmr;
  logic [3:0] w_tmr_nxt;
  logic [2:0] w_mux_nxt;
  logic [7:0] w_oe_nxt;
  logic [5:0] w_dsn_rst_nxt;
  logic       w_new_tgt;
  logic       w_diff_active;

  // Multi-hot requests are treated as "no design".
  assign w_multi = |(r_req & (r_req - 6'd1));
  assign w_clean = w_multi ? 6'd0 : r_req;

  // w_held = consecutive cycles the current clean request has been seen,
  // including this one; saturates at the settle length.
  always_comb begin
    w_held = 8'd1;
    if (w_clean == r_flt_val) begin
      if (r_flt_cnt >= SETTLE_TC) w_held = SETTLE_TC;
      else                        w_held = r_flt_cnt + 8'd1;
    end
  end

  assign w_acc         = (w_held == SETTLE_TC);
  assign w_new_tgt     = w_acc && (w_clean != r_tgt);
  assign w_diff_active = w_acc && (sel_idx(w_clean) != o_mux);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_req     <= 6'd0;
      r_flt_val <= 6'd0;
      r_flt_cnt <= 8'd0;
      o_err     <= 1'b0;
    end else begin
      r_req     <= i_sel;
      r_flt_val <= w_clean;
      r_flt_cnt <= w_held;
      o_err     <= o_err | w_multi;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_OFF;
      r_tgt     <= 6'd0;
      r_tmr     <= 4'd0;
      o_mux     <= MUX_NONE;
      o_oe      <= 8'h00;
      o_dsn_rst <= 6'h3F;
    end else begin
      r_state   <= w_state_nxt;
      r_tgt     <= w_tgt_nxt;
      r_tmr     <= w_tmr_nxt;
      o_mux     <= w_mux_nxt;
      o_oe      <= w_oe_nxt;
      o_dsn_rst <= w_dsn_rst_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_tmr_nxt   = r_tmr;
    w_mux_nxt   = o_mux;
    case (r_state)
      ST_OFF, ST_RUN: begin
        if (w_diff_active) begin
          w_state_nxt = ST_DRAIN;
          w_tgt_nxt   = w_clean;
          w_tmr_nxt   = OE_LOAD;
        end
      end
      ST_DRAIN: begin
        // A fresh target restarts the drain even on its last cycle.
        if (w_new_tgt) begin
          w_tgt_nxt = w_clean;
          w_tmr_nxt = OE_LOAD;
        end else if (r_tmr == 4'd0) begin
          w_mux_nxt = sel_idx(r_tgt);
          if (r_tgt == 6'd0) begin
            w_state_nxt = ST_OFF;
          end else begin
            w_state_nxt = ST_RESET;
            w_tmr_nxt   = RST_LOAD;
          end
        end else begin
          w_tmr_nxt = r_tmr - 4'd1;
        end
      end
      ST_RESET: begin
        if (w_new_tgt) begin
          w_state_nxt = ST_DRAIN;
          w_tgt_nxt   = w_clean;
          w_tmr_nxt   = OE_LOAD;
        end else if (r_tmr == 4'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_tmr_nxt = r_tmr - 4'd1;
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  // Pad enables and design resets are derived from the next state so they
  // change on the same edge as the state and mux, with no decode glitches.
  always_comb begin
    w_oe_nxt      = 8'h00;
    w_dsn_rst_nxt = 6'h3F;
    if (w_state_nxt == ST_RUN) begin
      w_oe_nxt      = 8'hFF;
      w_dsn_rst_nxt = ~(6'b000001 << w_mux_nxt);
    end
  end

  assign o_busy = (r_state == ST_DRAIN) || (r_state == ST_RESET);

endmodule

// File: tb/tb_switch_ctrl.sv
// Bench for switch_ctrl. Two instances: u_dut1 with default parameters and
// u_dut2 with a long post-switch reset so a second request can land during
// RESET. Stimulus pushes each expected output change (cycle stamp + values)
// into a per-DUT queue; the negedge monitor pops one entry for every change
// it observes on the outputs and compares.

module tb_switch_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1;
  logic       rst2 = 1'b1;
  logic [5:0] sel1 = 6'd0;
  logic [5:0] sel2 = 6'd0;

  logic [2:0] mux1, mux2;
  logic [5:0] dr1, dr2;
  logic [7:0] oe1, oe2;
  logic       busy1, busy2, err1, err2;

  switch_ctrl u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_sel(sel1),
    .o_mux(mux1), .o_dsn_rst(dr1), .o_oe(oe1), .o_busy(busy1), .o_err(err1)
  );

  switch_ctrl #(.pRST_CYC(15)) u_dut2 (
    .i_clk(clk), .i_rst(rst2), .i_sel(sel2),
    .o_mux(mux2), .o_dsn_rst(dr2), .o_oe(oe2), .o_busy(busy2), .o_err(err2)
  );

  typedef struct packed {
    logic [2:0] mux;
    logic [7:0] oe;
    logic [5:0] dr;
    logic       err;
    logic       busy;
  } obs_t;

  typedef struct packed {
    logic [31:0] cyc;
    obs_t        o;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;
  obs_t prev1, prev2;
  bit   seen1  = 1'b0;
  bit   seen2  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int d, input int c, input logic [2:0] m,
                           input logic [7:0] oe, input logic [5:0] dr,
                           input logic err, input logic busy);
    exp_t e;
    e.cyc    = c;
    e.o.mux  = m;
    e.o.oe   = oe;
    e.o.dr   = dr;
    e.o.err  = err;
    e.o.busy = busy;
    if (d == 1) q1.push_back(e);
    else        q2.push_back(e);
  endtask

  task automatic observe(input int d, input obs_t cur);
    exp_t e;
    bit   empty;
    checks++;
    empty = (d == 1) ? (q1.size() == 0) : (q2.size() == 0);
    if (empty) begin
      errors++;
      $display("FAIL unexpected_change dut%0d cyc=%0d got mux=%0d oe=%h dsn_rst=%h err=%b busy=%b, required no change",
               d, cyc, cur.mux, cur.oe, cur.dr, cur.err, cur.busy);
    end else begin
      if (d == 1) e = q1.pop_front();
      else        e = q2.pop_front();
      if (e.cyc != 32'(cyc) || e.o != cur) begin
        errors++;
        $display("FAIL output_event dut%0d got cyc=%0d mux=%0d oe=%h dsn_rst=%h err=%b busy=%b required cyc=%0d mux=%0d oe=%h dsn_rst=%h err=%b busy=%b",
                 d, cyc, cur.mux, cur.oe, cur.dr, cur.err, cur.busy,
                 e.cyc, e.o.mux, e.o.oe, e.o.dr, e.o.err, e.o.busy);
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    obs_t c1;
    obs_t c2;
    c1 = {mux1, oe1, dr1, err1, busy1};
    c2 = {mux2, oe2, dr2, err2, busy2};
    if (!seen1 || c1 != prev1) observe(1, c1);
    if (!seen2 || c2 != prev2) observe(2, c2);
    seen1 <= 1'b1;
    seen2 <= 1'b1;
    prev1 <= c1;
    prev2 <= c2;
    if (done) begin
      checks++;
      if (q1.size() != 0) begin
        errors++;
        $display("FAIL pending_events dut1 got %0d required 0", q1.size());
      end
      checks++;
      if (q2.size() != 0) begin
        errors++;
        $display("FAIL pending_events dut2 got %0d required 0", q2.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset state seen at the first sample
    expect_ev(1, 1, 3'd7, 8'h00, 6'h3F, 1'b0, 1'b0);
    expect_ev(2, 1, 3'd7, 8'h00, 6'h3F, 1'b0, 1'b0);

    // request design 2 held through reset release: RUN 15 cycles later
    step_to(3);
    rst1 = 1'b0;
    sel1 = 6'h04;
    expect_ev(1, 12, 3'd7, 8'h00, 6'h3F, 1'b0, 1'b1);
    expect_ev(1, 14, 3'd2, 8'h00, 6'h3F, 1'b0, 1'b1);
    expect_ev(1, 18, 3'd2, 8'hFF, 6'h3B, 1'b0, 1'b0);

    // 0x08/0x04 toggling every 3 cycles never settles: no output change
    step_to(20);
    for (int k = 0; k < 14; k++) begin
      sel1 = (k % 2 == 1) ? 6'h04 : 6'h08;
      step_to(20 + 3 * (k + 1));
    end

    // deselect: drain at +9, mux to 7 and OFF at +11
    step_to(70);
    sel1 = 6'h00;
    expect_ev(1, 79, 3'd2, 8'h00, 6'h3F, 1'b0, 1'b1);
    expect_ev(1, 81, 3'd7, 8'h00, 6'h3F, 1'b0, 1'b0);

    // multi-hot: err two cycles later, stays in OFF
    step_to(85);
    sel1 = 6'h03;
    expect_ev(1, 87, 3'd7, 8'h00, 6'h3F, 1'b1, 1'b0);

    // legal request afterwards still switches; err stays set
    step_to(90);
    sel1 = 6'h01;
    expect_ev(1, 99,  3'd7, 8'h00, 6'h3F, 1'b1, 1'b1);
    expect_ev(1, 101, 3'd0, 8'h00, 6'h3F, 1'b1, 1'b1);
    expect_ev(1, 105, 3'd0, 8'hFF, 6'h3E, 1'b1, 1'b0);

    // switch 0->5, reset pulse mid-RESET, held request re-qualifies
    step_to(108);
    sel1 = 6'h20;
    expect_ev(1, 117, 3'd0, 8'h00, 6'h3F, 1'b1, 1'b1);
    expect_ev(1, 119, 3'd5, 8'h00, 6'h3F, 1'b1, 1'b1);
    step_to(120);
    rst1 = 1'b1;
    expect_ev(1, 120, 3'd7, 8'h00, 6'h3F, 1'b0, 1'b0);
    step_to(121);
    rst1 = 1'b0;
    expect_ev(1, 130, 3'd7, 8'h00, 6'h3F, 1'b0, 1'b1);
    expect_ev(1, 132, 3'd5, 8'h00, 6'h3F, 1'b0, 1'b1);
    expect_ev(1, 136, 3'd5, 8'hFF, 6'h1F, 1'b0, 1'b0);

    // dut2 (15-cycle post-switch reset): bring up design 2
    step_to(140);
    rst2 = 1'b0;
    sel2 = 6'h04;
    expect_ev(2, 149, 3'd7, 8'h00, 6'h3F, 1'b0, 1'b1);
    expect_ev(2, 151, 3'd2, 8'h00, 6'h3F, 1'b0, 1'b1);
    expect_ev(2, 166, 3'd2, 8'hFF, 6'h3B, 1'b0, 1'b0);

    // switch 2->5, then request 0 during RESET: drain restarts, mux goes to 0,
    // pads stay disabled until the final RUN
    step_to(170);
    sel2 = 6'h20;
    expect_ev(2, 179, 3'd2, 8'h00, 6'h3F, 1'b0, 1'b1);
    expect_ev(2, 181, 3'd5, 8'h00, 6'h3F, 1'b0, 1'b1);
    step_to(181);
    sel2 = 6'h01;
    expect_ev(2, 192, 3'd0, 8'h00, 6'h3F, 1'b0, 1'b1);
    expect_ev(2, 207, 3'd0, 8'hFF, 6'h3E, 1'b0, 1'b0);

    step_to(215);
    done = 1'b1;
  end

endmodule
